// File: rtl/ad_serial_rx.sv
`default_nettype none
// ============================================================================
// Module      : ad_serial_rx
// Description : Serial front end for one ADC channel. Paces conversions at a
//               fixed sample period, generates cs_n/sclk from clk_sys, shifts
//               in an N_BITS MSB-first word from sdata and presents it as a
//               parallel sample with a one-cycle valid strobe.
// Ports       : clk_sys  in   system clock, all logic on the rising edge
//               rst      in   synchronous reset, active-high
//               en       in   1 = run periodic conversions
//               sdata    in   ADC serial data (ADC updates on sclk fall)
//               cs_n     out  ADC chip select, active-low, registered
//               sclk     out  ADC serial clock, idle high, registered
//               ad_data  out  last completed sample, held until next frame
//               ad_vld   out  one-cycle strobe, ad_data updated this cycle
//               ad_cnt   out  completed-frame counter, wraps 0xFFFF->0x0000
// Revision    : 1.0 - initial release
// ============================================================================
module ad_serial_rx #(
  parameter int N_BITS     = 16,
  parameter int CLK_DIV    = 2,
  parameter int CS_SETUP   = 2,
  parameter int SMP_PERIOD = 1000
) (
  input  logic              clk_sys,
  input  logic              rst,
  input  logic              en,
  input  logic              sdata,
  output logic              cs_n,
  output logic              sclk,
  output logic [N_BITS-1:0] ad_data,
  output logic              ad_vld,
  output logic [15:0]       ad_cnt
);

  localparam int FRAME_MIN = 2 + CS_SETUP + 2 * CLK_DIV * N_BITS;
  localparam int PCNT_W    = (SMP_PERIOD > 1) ? $clog2(SMP_PERIOD) : 1;
  localparam int CNT_MAX   = (CS_SETUP > 2 * CLK_DIV) ? CS_SETUP : 2 * CLK_DIV;
  localparam int CNT_W     = $clog2(CNT_MAX) + 1;
  localparam int BIT_W     = $clog2(N_BITS) + 1;

  // A sample period shorter than one full frame would let a tick land
  // while a frame is still in flight; refuse such configurations.
  generate
    if (SMP_PERIOD < FRAME_MIN || CLK_DIV < 1 || CS_SETUP < 1 || N_BITS < 2) begin : g_param_check
      $error("ad_serial_rx: illegal parameter combination");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [PCNT_W-1:0]   pcnt_q, pcnt_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;     // cycles within SETUP, or within one sclk period
  logic [BIT_W-1:0]    bit_q, bit_d;     // sclk period index within SHIFT
  logic [N_BITS-1:0]   shreg_q, shreg_d;
  logic [N_BITS-1:0]   ad_data_q, ad_data_d;
  logic [15:0]         ad_cnt_q, ad_cnt_d;
  logic                cs_n_q, cs_n_d;
  logic                sclk_q, sclk_d;
  logic                ad_vld_q, ad_vld_d;
  logic                tick;

  assign tick = en && (pcnt_q == '0);

  always_ff @(posedge clk_sys) begin
    if (rst) begin
      state_q   <= IDLE;
      pcnt_q    <= '0;
      cnt_q     <= '0;
      bit_q     <= '0;
      shreg_q   <= '0;
      ad_data_q <= '0;
      ad_cnt_q  <= '0;
      cs_n_q    <= 1'b1;
      sclk_q    <= 1'b1;
      ad_vld_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      pcnt_q    <= pcnt_d;
      cnt_q     <= cnt_d;
      bit_q     <= bit_d;
      shreg_q   <= shreg_d;
      ad_data_q <= ad_data_d;
      ad_cnt_q  <= ad_cnt_d;
      cs_n_q    <= cs_n_d;
      sclk_q    <= sclk_d;
      ad_vld_q  <= ad_vld_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_d     = bit_q;
    shreg_d   = shreg_q;
    ad_data_d = ad_data_q;
    ad_cnt_d  = ad_cnt_q;

    // Period counter. A tick that arrives while a frame is still running
    // (only possible right after en is re-asserted) is not consumed: pcnt
    // stays at 0 so the first tick is taken once the FSM is back in IDLE.
    if (!en) begin
      pcnt_d = '0;
    end else if (tick && (state_q != IDLE)) begin
      pcnt_d = '0;
    end else if (pcnt_q == PCNT_W'(SMP_PERIOD - 1)) begin
      pcnt_d = '0;
    end else begin
      pcnt_d = pcnt_q + PCNT_W'(1);
    end

    case (state_q)
      IDLE: begin
        if (tick) begin
          state_d = SETUP;
          cnt_d   = '0;
        end
      end
      SETUP: begin
        if (cnt_q == CNT_W'(CS_SETUP - 1)) begin
          state_d = SHIFT;
          cnt_d   = '0;
          bit_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      SHIFT: begin
        // Last low cycle of the period: this edge raises sclk, so sample here.
        if (cnt_q == CNT_W'(CLK_DIV - 1)) begin
          shreg_d = {shreg_q[N_BITS-2:0], sdata};
        end
        if (cnt_q == CNT_W'(2 * CLK_DIV - 1)) begin
          cnt_d = '0;
          if (bit_q == BIT_W'(N_BITS - 1)) begin
            state_d   = DONE;
            ad_data_d = shreg_q;
            ad_cnt_d  = ad_cnt_q + 16'd1;
          end else begin
            bit_d = bit_q + BIT_W'(1);
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Outputs are registered, so they are decoded from the next state.
    cs_n_d   = !((state_d == SETUP) || (state_d == SHIFT));
    sclk_d   = !((state_d == SHIFT) && (cnt_d < CNT_W'(CLK_DIV)));
    ad_vld_d = (state_d == DONE);
  end

  assign cs_n    = cs_n_q;
  assign sclk    = sclk_q;
  assign ad_data = ad_data_q;
  assign ad_vld  = ad_vld_q;
  assign ad_cnt  = ad_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_ad_serial_rx.sv
`default_nettype none
// ============================================================================
// Module      : tb_ad_serial_rx
// Description : Self-checking bench for ad_serial_rx. Two instances: one with
//               default parameters, one with CLK_DIV=1, CS_SETUP=1,
//               SMP_PERIOD=40. A behavioural ADC model serves words (fixed or
//               $urandom) MSB first on sclk falling edges; expected samples
//               and strobe times come from the word served and the frame
//               timing arithmetic 1 + CS_SETUP + 2*CLK_DIV*N_BITS.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ad_serial_rx;

  localparam int N = 16;

  logic        clk_sys = 1'b0;
  logic        rst0 = 1'b1, en0 = 1'b0, sdata0 = 1'b0;
  logic        rst1 = 1'b1, en1 = 1'b0, sdata1 = 1'b0;
  logic        cs_n0, sclk0, ad_vld0, cs_n1, sclk1, ad_vld1;
  logic [15:0] ad_data0, ad_cnt0, ad_data1, ad_cnt1;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  initial forever #5 clk_sys = ~clk_sys;
  initial forever begin @(posedge clk_sys); cyc++; end

  ad_serial_rx dut (
    .clk_sys(clk_sys), .rst(rst0), .en(en0), .sdata(sdata0),
    .cs_n(cs_n0), .sclk(sclk0), .ad_data(ad_data0), .ad_vld(ad_vld0), .ad_cnt(ad_cnt0)
  );

  ad_serial_rx #(.N_BITS(16), .CLK_DIV(1), .CS_SETUP(1), .SMP_PERIOD(40)) dut6 (
    .clk_sys(clk_sys), .rst(rst1), .en(en1), .sdata(sdata1),
    .cs_n(cs_n1), .sclk(sclk1), .ad_data(ad_data1), .ad_vld(ad_vld1), .ad_cnt(ad_cnt1)
  );

  // Strobe latency after the tick cycle.
  function automatic int lat(input int clk_div, input int cs_setup);
    return 1 + cs_setup + 2 * clk_div * N;
  endfunction

  // ---------------- ADC models ----------------
  logic [15:0] word0_q[$], word1_q[$];
  logic [15:0] cur0 = '0, cur1 = '0;
  int          idx0 = -1, idx1 = -1;

  initial forever begin
    @(negedge cs_n0);
    if (word0_q.size() > 0) cur0 = word0_q.pop_front(); else cur0 = 16'($urandom);
    idx0 = N - 1;
  end
  initial forever begin
    @(negedge sclk0);
    if (cs_n0 === 1'b0 && idx0 >= 0) begin sdata0 = cur0[idx0]; idx0--; end
  end
  initial forever begin
    @(negedge cs_n1);
    if (word1_q.size() > 0) cur1 = word1_q.pop_front(); else cur1 = 16'($urandom);
    idx1 = N - 1;
  end
  initial forever begin
    @(negedge sclk1);
    if (cs_n1 === 1'b0 && idx1 >= 0) begin sdata1 = cur1[idx1]; idx1--; end
  end

  // ---------------- Bus monitor ----------------
  typedef struct {
    int          cyc;
    logic [15:0] data;
    logic [15:0] cnt;
    int          rises;
    int          min_sp;
    int          max_sp;
  } vld_rec_t;

  vld_rec_t vq[2][$];
  int       fall_q[2][$];
  int       hi_q[2][$];

  initial begin
    logic        pcs[2], psc[2], cs[2], sc[2], vl[2];
    logic [15:0] dt[2], ct[2];
    int          hi[2], rises[2], lastr[2], mn[2], mx[2];
    vld_rec_t    r;
    for (int k = 0; k < 2; k++) begin
      pcs[k] = 1'b1; psc[k] = 1'b1; hi[k] = 0; rises[k] = 0; lastr[k] = 0; mn[k] = 0; mx[k] = 0;
    end
    forever begin
      @(negedge clk_sys);
      cs[0] = cs_n0;   cs[1] = cs_n1;
      sc[0] = sclk0;   sc[1] = sclk1;
      vl[0] = ad_vld0; vl[1] = ad_vld1;
      dt[0] = ad_data0; dt[1] = ad_data1;
      ct[0] = ad_cnt0;  ct[1] = ad_cnt1;
      for (int k = 0; k < 2; k++) begin
        if (pcs[k] === 1'b1 && cs[k] === 1'b0) begin
          fall_q[k].push_back(cyc);
          hi_q[k].push_back(hi[k]);
          rises[k] = 0; mn[k] = 1000000; mx[k] = 0;
        end
        hi[k] = (cs[k] === 1'b1) ? hi[k] + 1 : 0;
        if (psc[k] === 1'b0 && sc[k] === 1'b1 && cs[k] === 1'b0) begin
          if (rises[k] > 0) begin
            if (cyc - lastr[k] < mn[k]) mn[k] = cyc - lastr[k];
            if (cyc - lastr[k] > mx[k]) mx[k] = cyc - lastr[k];
          end
          rises[k]++;
          lastr[k] = cyc;
        end
        if (vl[k] === 1'b1) begin
          r.cyc = cyc; r.data = dt[k]; r.cnt = ct[k]; r.rises = rises[k];
          r.min_sp = mn[k]; r.max_sp = mx[k];
          vq[k].push_back(r);
        end
        pcs[k] = cs[k];
        psc[k] = sc[k];
      end
    end
  end

  // ---------------- Stepping and bounded waits ----------------
  task automatic step();
    @(negedge clk_sys);
    #1;
  endtask

  task automatic step_until(input int c);
    while (cyc < c) step();
  endtask

  task automatic wait_vld(input int k, input int budget, output bit ok, output vld_rec_t r);
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      if (vq[k].size() > 0) ok = 1'b1; else step();
    end
    if (!ok && vq[k].size() > 0) ok = 1'b1;
    if (ok) r = vq[k].pop_front();
    else r = '{default: 0};
  endtask

  task automatic wait_fall(input int k, input int budget, output bit ok, output int f);
    ok = 1'b0;
    f  = 0;
    for (int i = 0; i < budget && !ok; i++) begin
      if (fall_q[k].size() > 0) ok = 1'b1; else step();
    end
    if (!ok && fall_q[k].size() > 0) ok = 1'b1;
    if (ok) f = fall_q[k].pop_front();
  endtask

  // ---------------- Tests ----------------
  int last_vld0 = 0;
  logic [15:0] last_cnt0 = '0;

  task automatic test_reset();
    rst0 = 1'b1; rst1 = 1'b1; en0 = 1'b0; en1 = 1'b0;
    repeat (4) step();
    checks++; if (cs_n0 !== 1'b1)    begin failures++; $display("FAIL reset_cs_n got=%b exp=1", cs_n0); end
    checks++; if (sclk0 !== 1'b1)    begin failures++; $display("FAIL reset_sclk got=%b exp=1", sclk0); end
    checks++; if (ad_data0 !== 16'h0) begin failures++; $display("FAIL reset_ad_data got=%h exp=0000", ad_data0); end
    checks++; if (ad_vld0 !== 1'b0)  begin failures++; $display("FAIL reset_ad_vld got=%b exp=0", ad_vld0); end
    checks++; if (ad_cnt0 !== 16'h0) begin failures++; $display("FAIL reset_ad_cnt got=%h exp=0000", ad_cnt0); end
    checks++; if (cs_n1 !== 1'b1 || sclk1 !== 1'b1 || ad_cnt1 !== 16'h0)
      begin failures++; $display("FAIL reset_dut6 got cs_n=%b sclk=%b cnt=%h exp 1 1 0000", cs_n1, sclk1, ad_cnt1); end
  endtask

  task automatic test_first_frame();
    bit ok; vld_rec_t r; int c0, f;
    word0_q.push_back(16'hA5C3);
    rst0 = 1'b0; en0 = 1'b1; c0 = cyc;
    wait_fall(0, 10, ok, f);
    checks++; if (!ok || f - c0 !== 1) begin failures++; $display("FAIL first_cs_low got=%0d exp=1 (ok=%0b)", f - c0, ok); end
    wait_vld(0, 200, ok, r);
    checks++; if (!ok) begin failures++; $display("FAIL first_vld_timeout got=none exp=strobe"); end
    else begin
      checks++; if (r.cyc - c0 !== lat(2, 2)) begin failures++; $display("FAIL first_vld_cycle got=%0d exp=%0d", r.cyc - c0, lat(2, 2)); end
      checks++; if (r.data !== 16'hA5C3) begin failures++; $display("FAIL first_data got=%h exp=a5c3", r.data); end
      checks++; if (r.cnt !== 16'd1)     begin failures++; $display("FAIL first_cnt got=%h exp=0001", r.cnt); end
      checks++; if (r.rises !== N)       begin failures++; $display("FAIL first_sclk_rises got=%0d exp=%0d", r.rises, N); end
      checks++; if (r.min_sp !== 4 || r.max_sp !== 4)
        begin failures++; $display("FAIL first_sclk_period got=%0d..%0d exp=4", r.min_sp, r.max_sp); end
      last_vld0 = r.cyc; last_cnt0 = r.cnt;
    end
    hi_q[0].delete();
  endtask

  task automatic test_free_run();
    bit ok; vld_rec_t r;
    logic [15:0] words[5];
    words = '{16'h0000, 16'hFFFF, 16'h8001, 16'h7FFE, 16'h1234};
    for (int i = 0; i < 5; i++) word0_q.push_back(words[i]);
    for (int i = 0; i < 5; i++) begin
      wait_vld(0, 1100, ok, r);
      checks++; if (!ok) begin failures++; $display("FAIL free_vld_timeout frame=%0d got=none exp=strobe", i); end
      else begin
        checks++; if (r.cyc - last_vld0 !== 1000) begin failures++; $display("FAIL free_period frame=%0d got=%0d exp=1000", i, r.cyc - last_vld0); end
        checks++; if (r.data !== words[i]) begin failures++; $display("FAIL free_data frame=%0d got=%h exp=%h", i, r.data, words[i]); end
        checks++; if (r.cnt !== last_cnt0 + 16'd1) begin failures++; $display("FAIL free_cnt frame=%0d got=%h exp=%h", i, r.cnt, last_cnt0 + 16'd1); end
        checks++; if (hi_q[0].size() == 0 || hi_q[0][0] < 933)
          begin failures++; $display("FAIL free_cs_high frame=%0d got=%0d exp>=933", i, (hi_q[0].size() > 0) ? hi_q[0][0] : -1); end
        if (hi_q[0].size() > 0) void'(hi_q[0].pop_front());
        last_vld0 = r.cyc; last_cnt0 = r.cnt;
      end
    end
    fall_q[0].delete();
  endtask

  task automatic test_en_drop();
    bit ok; vld_rec_t r; int f, tick, e;
    logic [15:0] w1, w2;
    w1 = 16'($urandom); w2 = 16'($urandom);
    word0_q.push_back(w1);
    wait_fall(0, 1100, ok, f);
    tick = f - 1;
    step_until(tick + 20);
    en0 = 1'b0;
    wait_vld(0, 200, ok, r);
    checks++; if (!ok || r.cyc - tick !== lat(2, 2)) begin failures++; $display("FAIL endrop_vld_cycle got=%0d exp=%0d", r.cyc - tick, lat(2, 2)); end
    checks++; if (r.data !== w1) begin failures++; $display("FAIL endrop_data got=%h exp=%h", r.data, w1); end
    last_cnt0 = r.cnt;
    repeat ($urandom_range(1100, 1500)) step();
    checks++; if (fall_q[0].size() != 0) begin failures++; $display("FAIL endrop_no_cs got=%0d frames exp=0", fall_q[0].size()); end
    fall_q[0].delete();
    word0_q.push_back(w2);
    en0 = 1'b1; e = cyc;
    wait_fall(0, 10, ok, f);
    checks++; if (!ok || f - e !== 1) begin failures++; $display("FAIL enret_cs_low got=%0d exp=1", f - e); end
    wait_vld(0, 200, ok, r);
    checks++; if (!ok || r.cyc - e !== lat(2, 2) || r.data !== w2 || r.cnt !== last_cnt0 + 16'd1)
      begin failures++; $display("FAIL enret_frame got cyc=%0d data=%h cnt=%h exp cyc=%0d data=%h cnt=%h", r.cyc - e, r.data, r.cnt, lat(2, 2), w2, last_cnt0 + 16'd1); end
  endtask

  task automatic test_reset_midframe();
    bit ok; vld_rec_t r; int f, tick, rc;
    logic [15:0] wa, wb;
    wa = 16'($urandom); wb = 16'($urandom);
    word0_q.push_back(wa); word0_q.push_back(wb);
    wait_fall(0, 1100, ok, f);
    checks++; if (!ok) begin failures++; $display("FAIL rstmid_no_frame got=none exp=cs_n low"); end
    tick = f - 1;
    step_until(tick + 40);
    rst0 = 1'b1;
    step();
    checks++; if (cs_n0 !== 1'b1 || sclk0 !== 1'b1 || ad_vld0 !== 1'b0)
      begin failures++; $display("FAIL rstmid_ctrl got cs_n=%b sclk=%b vld=%b exp 1 1 0", cs_n0, sclk0, ad_vld0); end
    checks++; if (ad_data0 !== 16'h0 || ad_cnt0 !== 16'h0)
      begin failures++; $display("FAIL rstmid_regs got data=%h cnt=%h exp 0000 0000", ad_data0, ad_cnt0); end
    rst0 = 1'b0; rc = cyc;
    wait_vld(0, 200, ok, r);
    checks++; if (!ok || r.cyc - rc !== lat(2, 2)) begin failures++; $display("FAIL rstmid_vld_cycle got=%0d exp=%0d", r.cyc - rc, lat(2, 2)); end
    checks++; if (r.data !== wb || r.cnt !== 16'd1)
      begin failures++; $display("FAIL rstmid_next_frame got data=%h cnt=%h exp %h 0001", r.data, r.cnt, wb); end
    last_vld0 = r.cyc;
  endtask

  task automatic test_cnt_wrap();
    bit ok; vld_rec_t r;
    logic [15:0] w[2];
    logic [15:0] exp_cnt[2];
    w[0] = 16'($urandom); w[1] = 16'($urandom);
    exp_cnt[0] = 16'hFFFF; exp_cnt[1] = 16'h0000;
    force dut.ad_cnt_q = 16'hFFFE;
    step();
    release dut.ad_cnt_q;
    word0_q.push_back(w[0]); word0_q.push_back(w[1]);
    for (int i = 0; i < 2; i++) begin
      wait_vld(0, 1100, ok, r);
      checks++; if (!ok || r.cnt !== exp_cnt[i]) begin failures++; $display("FAIL wrap_cnt frame=%0d got=%h exp=%h", i, r.cnt, exp_cnt[i]); end
      checks++; if (r.data !== w[i] || r.cyc - last_vld0 !== 1000)
        begin failures++; $display("FAIL wrap_frame frame=%0d got data=%h dt=%0d exp %h 1000", i, r.data, r.cyc - last_vld0, w[i]); end
      last_vld0 = r.cyc;
    end
  endtask

  task automatic test_fast_cfg();
    bit ok; vld_rec_t r; int c0, f;
    logic [15:0] w2;
    w2 = 16'($urandom);
    word1_q.push_back(16'h5A5A); word1_q.push_back(w2);
    rst1 = 1'b0; en1 = 1'b1; c0 = cyc;
    wait_fall(1, 10, ok, f);
    checks++; if (!ok || f - c0 !== 1) begin failures++; $display("FAIL fast_cs_low got=%0d exp=1", f - c0); end
    wait_vld(1, 100, ok, r);
    checks++; if (!ok || r.cyc - c0 !== lat(1, 1)) begin failures++; $display("FAIL fast_vld_cycle got=%0d exp=%0d", r.cyc - c0, lat(1, 1)); end
    checks++; if (r.data !== 16'h5A5A || r.cnt !== 16'd1)
      begin failures++; $display("FAIL fast_data got data=%h cnt=%h exp 5a5a 0001", r.data, r.cnt); end
    checks++; if (r.rises !== N || r.min_sp !== 2 || r.max_sp !== 2)
      begin failures++; $display("FAIL fast_sclk got rises=%0d period=%0d..%0d exp %0d 2..2", r.rises, r.min_sp, r.max_sp, N); end
    wait_vld(1, 100, ok, r);
    checks++; if (!ok || r.cyc - c0 !== 40 + lat(1, 1) || r.data !== w2 || r.cnt !== 16'd2)
      begin failures++; $display("FAIL fast_second got cyc=%0d data=%h cnt=%h exp %0d %h 0002", r.cyc - c0, r.data, r.cnt, 40 + lat(1, 1), w2); end
  endtask

  initial begin
    test_reset();
    test_first_frame();
    test_free_run();
    test_en_drop();
    test_reset_midframe();
    test_cnt_wrap();
    test_fast_cfg();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog got=timeout exp=finish checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
